// File: rtl/pol_out_packer.sv
// Serializes each pooled vector into NUM_WORDS global-buffer writes at consecutive addresses, then pulses Done.
// First write one cycle after input handshake; WrAddr/WrDat hold under WrRdy=0 and DatInRdy stays low until the point drains.
module pol_out_packer #(
  parameter int NUM_MAX    = 64,
  parameter int DATA_WIDTH = 8,
  parameter int SRAM_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           Rst,
  input  logic                           CfgVld,
  output logic                           CfgRdy,
  input  logic [ADDR_WIDTH-1:0]          CfgBaseAddr,
  input  logic [ADDR_WIDTH-1:0]          CfgNumPnt,
  input  logic                           DatInVld,
  input  logic [DATA_WIDTH*NUM_MAX-1:0]  DatIn,
  output logic                           DatInRdy,
  output logic                           WrVld,
  output logic [ADDR_WIDTH-1:0]          WrAddr,
  output logic [SRAM_WIDTH-1:0]          WrDat,
  input  logic                           WrRdy,
  output logic                           Done
);

  localparam int NUM_WORDS = DATA_WIDTH * NUM_MAX / SRAM_WIDTH;
  localparam int WCW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_IN, SEND, DONE} state_t;

  state_t                                state_q;
  logic [NUM_WORDS-1:0][SRAM_WIDTH-1:0]  buf_q;
  logic [ADDR_WIDTH-1:0]                 addr_q;
  logic [ADDR_WIDTH-1:0]                 num_pnt_q;
  logic [ADDR_WIDTH-1:0]                 pnt_cnt_q;
  logic [WCW-1:0]                        word_cnt_q;

  // addr_q is a running write pointer: it starts at the base address and
  // advances once per accepted write, which equals Base + Pnt*NUM_WORDS + Word mod 2^ADDR_WIDTH.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      addr_q     <= '0;
      num_pnt_q  <= '0;
      pnt_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (CfgVld) begin
            addr_q     <= CfgBaseAddr;
            num_pnt_q  <= CfgNumPnt;
            pnt_cnt_q  <= '0;
            word_cnt_q <= '0;
            state_q    <= (CfgNumPnt == '0) ? DONE : WAIT_IN;
          end
        end
        WAIT_IN: begin
          if (DatInVld) begin
            buf_q   <= DatIn;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (WrRdy) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_q <= '0;
              pnt_cnt_q  <= pnt_cnt_q + ADDR_WIDTH'(1);
              state_q    <= (pnt_cnt_q == num_pnt_q - ADDR_WIDTH'(1)) ? DONE : WAIT_IN;
            end else begin
              word_cnt_q <= word_cnt_q + WCW'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CfgRdy   = (state_q == IDLE);
  assign DatInRdy = (state_q == WAIT_IN);
  assign WrVld    = (state_q == SEND);
  assign Done     = (state_q == DONE);
  assign WrAddr   = WrVld ? addr_q : '0;
  assign WrDat    = WrVld ? buf_q[word_cnt_q] : '0;

endmodule

// File: tb/tb_pol_out_packer.sv
// Directed bench for pol_out_packer: reset, single point, backpressure, zero points, wrap, reset mid-batch.
module tb_pol_out_packer;

  localparam int AW = 16;
  localparam int VW = 512;
  localparam int SW = 128;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          Rst = 1'b1;
  logic          CfgVld = 1'b0;
  logic          CfgRdy;
  logic [AW-1:0] CfgBaseAddr = '0;
  logic [AW-1:0] CfgNumPnt = '0;
  logic          DatInVld = 1'b0;
  logic [VW-1:0] DatIn = '0;
  logic          DatInRdy;
  logic          WrVld;
  logic [AW-1:0] WrAddr;
  logic [SW-1:0] WrDat;
  logic          WrRdy = 1'b0;
  logic          Done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pol_out_packer dut (
    .clk(clk), .Rst(Rst),
    .CfgVld(CfgVld), .CfgRdy(CfgRdy), .CfgBaseAddr(CfgBaseAddr), .CfgNumPnt(CfgNumPnt),
    .DatInVld(DatInVld), .DatIn(DatIn), .DatInRdy(DatInRdy),
    .WrVld(WrVld), .WrAddr(WrAddr), .WrDat(WrDat), .WrRdy(WrRdy),
    .Done(Done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input int seed);
    logic [VW-1:0] v;
    for (int i = 0; i < 64; i++) v[8*i +: 8] = 8'(i + seed);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [AW-1:0] base, input logic [AW-1:0] num);
    chk("cfg_rdy", CfgRdy, 1);
    CfgVld      = 1'b1;
    CfgBaseAddr = base;
    CfgNumPnt   = num;
    step();
    CfgVld      = 1'b0;
  endtask

  // Drives vectors and WrRdy cycle by cycle, checking every write against base+index
  // and the channel slice of the vector accepted for that point.
  task automatic run_batch(input logic [AW-1:0] base, input int num, input int seed,
                           input bit stall, input int abort_after);
    int            acc = 0;
    int            nwr = 0;
    bit            in_hs_prev = 0;
    bit            last_wr_prev = 0;
    bit            tgl = 0;
    logic [VW-1:0] cur;
    logic [AW-1:0] ea;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (abort_after > 0 && nwr == abort_after) begin
        Rst = 1'b1; WrRdy = 1'b1; DatInVld = 1'b1;
        step();
        Rst = 1'b0; DatInVld = 1'b0;
        chk("rst_cfgrdy", CfgRdy, 1);
        chk("rst_wrvld", WrVld, 0);
        chk("rst_done", Done, 0);
        for (int k = 0; k < 3; k++) begin
          step();
          chk("rst_no_done", Done, 0);
        end
        return;
      end
      DatInVld = 1'b1;
      DatIn    = mkvec(seed + acc);
      tgl      = ~tgl;
      WrRdy    = stall ? tgl : 1'b1;
      if (in_hs_prev) chk("in2wr_lat", WrVld, 1);
      if (last_wr_prev) begin
        chk("done_lat", Done, 1);
        chk("nwrites", nwr, num * NW);
        chk("done_cfgrdy", CfgRdy, 0);
        DatInVld = 1'b0;
        step();
        chk("done_pulse", Done, 0);
        chk("idle_cfgrdy", CfgRdy, 1);
        return;
      end
      chk("early_done", Done, 0);
      chk("rdy_overlap", DatInRdy & WrVld, 0);
      if (WrVld) begin
        ea  = base + AW'(nwr);
        cur = mkvec(seed + nwr / NW);
        chk("wr_addr", WrAddr, ea);
        chk("wr_dat", WrDat, cur[SW*(nwr % NW) +: SW]);
        if (seed == 0 && nwr == 0)
          chk("w0_lit", WrDat, 128'h0F0E0D0C0B0A09080706050403020100);
      end else begin
        chk("addr_idle", WrAddr, 0);
        chk("dat_idle", WrDat, 0);
      end
      in_hs_prev = DatInVld && DatInRdy;
      if (in_hs_prev) acc++;
      last_wr_prev = 1'b0;
      if (WrVld && WrRdy) begin
        nwr++;
        last_wr_prev = (nwr == num * NW);
      end
      step();
    end
    chk("timeout_done", Done, 1);
  endtask

  initial begin
    // reset held with every input valid asserted
    Rst = 1'b1; CfgVld = 1'b1; DatInVld = 1'b1; WrRdy = 1'b1;
    step();
    step();
    chk("rst_cfgrdy0", CfgRdy, 1);
    chk("rst_wrvld0", WrVld, 0);
    chk("rst_datrdy0", DatInRdy, 0);
    chk("rst_done0", Done, 0);
    chk("rst_addr0", WrAddr, 0);
    chk("rst_dat0", WrDat, 0);
    CfgVld = 1'b0; DatInVld = 1'b0; Rst = 1'b0;
    step();

    cfg(16'h0100, 16'd1);
    run_batch(16'h0100, 1, 0, 1'b0, 0);

    cfg(16'h0010, 16'd2);
    run_batch(16'h0010, 2, 5, 1'b1, 0);

    DatInVld = 1'b1;
    cfg(16'h0050, 16'd0);
    chk("zero_done", Done, 1);
    chk("zero_cfgrdy", CfgRdy, 0);
    chk("zero_wrvld", WrVld, 0);
    chk("zero_datrdy", DatInRdy, 0);
    step();
    chk("zero_done_end", Done, 0);
    chk("zero_idle", CfgRdy, 1);
    chk("zero_datrdy2", DatInRdy, 0);
    DatInVld = 1'b0;

    cfg(16'hFFFE, 16'd1);
    run_batch(16'hFFFE, 1, 9, 1'b0, 0);

    cfg(16'h0300, 16'd3);
    run_batch(16'h0300, 3, 20, 1'b0, 6);

    cfg(16'h0200, 16'd1);
    run_batch(16'h0200, 1, 33, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
